di_reg_terminal: RTL
====================

// Module: di_reg_terminal
// PURPOSE
//  Register terminal directly downstream of the host interface's device interface (di* bus).
//  Decodes diEpAddr against its endpoint and serves diRegAddr reads and writes.
//  Holds RW control registers with per-register one-shot write triggers, and exposes RO status words.
//  Returns read data with a fixed latency and a one-cycle rdwr_ready completion strobe.
// PARAMETERS
//  EP_ADDR      16'h0001  endpoint this terminal answers to
//  NUM_REGS     8         number of 16-bit RW registers, 1..64
//  NUM_STATUS   4         number of 16-bit RO status words, 0..64
//  RD_LATENCY   2         cycles from diRead sample to rdwr_ready, 1..7
//  RESET_VALUES 0         NUM_REGS*16 flat reset/default value; reg i = bits [16i+15:16i]
// PORTS
//  if_clock      in   1                single clock, all logic on posedge
//  resetb        in   1                synchronous, active-low reset
//  diEpAddr      in   16               selected endpoint
//  diRegAddr     in   16               register address within endpoint
//  diRegDataIn   in   16               write data
//  diWrite       in   1                one-cycle write strobe
//  diRead        in   1                read request
//  diReset       in   1                soft reset, global (not endpoint-qualified)
//  diRegDataOut  out  16               read data; held until next read completes
//  rdwr_ready    out  1                one-cycle read-complete strobe
//  regs_flat     out  NUM_REGS*16      current RW register contents
//  trig          out  NUM_REGS         trig[i] pulses 1 cycle after write to reg i
//  status_flat   in   NUM_STATUS*16    RO status words, sampled at read completion
//  bad_addr      out  1                sticky: access to unmapped/RO-write address
// BEHAVIOUR
//  - Select: sel = (diEpAddr == EP_ADDR). Non-selected diRead/diWrite are ignored entirely.
//  - Map (full 16-bit compare): 0..NUM_REGS-1 RW; NUM_REGS..NUM_REGS+NUM_STATUS-1 RO; else unmapped.
//  - Write (sel & diWrite, RW addr): reg updated at that edge; trig[addr] high the next cycle only.
//  - Write to RO or unmapped: no register change, no trig, bad_addr <= 1.
//  - Read FSM states IDLE -> WAIT -> DONE -> IDLE:
//    - IDLE: sel & diRead -> latch diRegAddr, cnt <= RD_LATENCY-1; enter DONE directly if RD_LATENCY=1, else WAIT.
//    - WAIT: cnt decrements; cnt==1 -> DONE.
//    - DONE: diRegDataOut <= data(latched addr) and rdwr_ready=1 for exactly this cycle; -> IDLE.
//  - Latency: diRead high in cycle c -> rdwr_ready high in cycle c+RD_LATENCY.
//  - Read data: RW reg value at completion time (reflects any write during WAIT); RO = status_flat sampled at completion.
//  - Unmapped read: returns 16'hDEAD, sets bad_addr, still completes normally.
//  - diRead while not IDLE: ignored; no queueing.
//  - diRead held high across completion: the new request is accepted only on the cycle after DONE.
//  - Same-cycle diWrite+diRead, same addr: the write lands first, and the read returns the new value.
//  - diReset=1: regs <= RESET_VALUES, trig <= 0, bad_addr <= 0, FSM -> IDLE (in-flight read aborted, no rdwr_ready).
//    diRegDataOut keeps its value. diReset beats a simultaneous diWrite.
//  - resetb=0 (sync): same as diReset, plus diRegDataOut <= 0 and rdwr_ready <= 0.
//    A mid-read resetb aborts the read with no strobe.
//  - Reset values: regs_flat=RESET_VALUES, trig=0, bad_addr=0, diRegDataOut=0, rdwr_ready=0, FSM=IDLE.
// STRUCTURE
//  - Shared package di_pkg:
//    - read FSM state encoding (IDLE/WAIT/DONE, 2 bits);
//    - DI_UNMAPPED_DATA = 16'hDEAD;
//    - DI_DATA_W = 16.
//  - One sub-module, di_rd_timer: 3-bit down-counter with load and one-cycle done pulse, driven by the FSM.
//  - Register array, decode and output mux stay in di_reg_terminal.
// TESTING
//  1. Reset: resetb=0 two cycles, RESET_VALUES reg0=16'h1234
//     -> regs_flat[15:0]=16'h1234, trig=0, diRegDataOut=0, bad_addr=0.
//  2. Write/read: ep=1, addr=3, write 16'hBEEF, then diRead, RD_LATENCY=2
//     -> trig[3] high one cycle after write; rdwr_ready exactly 2 cycles after diRead, diRegDataOut=16'hBEEF.
//  3. Wrong endpoint: ep=2, write addr 0 = 16'h5555, read addr 0
//     -> reg0 unchanged, trig=0, rdwr_ready never asserts.
//  4. Map edges: status_flat word0=16'hA5A5
//     - read addr 8 (=NUM_REGS) -> 16'hA5A5;
//     - read addr 12 -> 16'hDEAD and bad_addr=1;
//     - write addr 8 -> bad_addr stays 1, no trig.
//  5. Overlap: write 16'h0042 to addr 1 in the cycle after diRead addr 1 (RD_LATENCY=3)
//     -> returns 16'h0042; second diRead during WAIT ignored (one strobe only).
//  6. Abort: diReset in WAIT
//     -> no rdwr_ready; regs back to RESET_VALUES, bad_addr=0; next read completes normally.

Source files
------------

// File: rtl/di_pkg.sv
// Shared constants for the di* register terminal: data width, read FSM encoding,
// and the filler word returned for unmapped reads.
package di_pkg;

    localparam int DI_DATA_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DI_DATA_W-1:0] DI_UNMAPPED_DATA = 16'hDEAD;

endpackage

// File: rtl/di_rd_timer.sv
// Read-latency timer: 3-bit down-counter with load, clear and a one-cycle done pulse
// raised while enabled on the final count.
module di_rd_timer (
    input  logic       if_clock,
    input  logic       resetb,
    input  logic       clr,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       en,
    output logic       done
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = 3'd0;
        else if (load)
            cnt_d = load_val;
        else if (en && cnt_q != 3'd0)
            cnt_d = cnt_q - 3'd1;
    end

    assign done = en && (cnt_q == 3'd1);

    always_ff @(posedge if_clock) begin
        if (!resetb)
            cnt_q <= 3'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/di_reg_terminal.sv
// Register terminal on the di* bus: endpoint decode, RW control registers with
// one-shot write triggers, RO status words, fixed-latency reads with a ready strobe.
module di_reg_terminal
    import di_pkg::*;
#(
    parameter logic [15:0] EP_ADDR    = 16'h0001,
    parameter int          NUM_REGS   = 8,
    parameter int          NUM_STATUS = 4,
    parameter int          RD_LATENCY = 2,
    parameter logic [NUM_REGS*DI_DATA_W-1:0] RESET_VALUES = '0,
    localparam int         ST_N = (NUM_STATUS > 0) ? NUM_STATUS : 1
) (
    input  logic                            if_clock,
    input  logic                            resetb,
    input  logic [15:0]                     diEpAddr,
    input  logic [15:0]                     diRegAddr,
    input  logic [DI_DATA_W-1:0]            diRegDataIn,
    input  logic                            diWrite,
    input  logic                            diRead,
    input  logic                            diReset,
    output logic [DI_DATA_W-1:0]            diRegDataOut,
    output logic                            rdwr_ready,
    output logic [NUM_REGS*DI_DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]             trig,
    input  logic [ST_N*DI_DATA_W-1:0]       status_flat,
    output logic                            bad_addr
);

    logic [NUM_REGS-1:0][DI_DATA_W-1:0] regs_q, regs_d;
    logic [ST_N-1:0][DI_DATA_W-1:0]     status_w;
    logic [NUM_REGS-1:0]                trig_q, trig_d;
    logic [1:0]                         state_q, state_d;
    logic [15:0]                        addr_q, addr_d, rd_addr;
    logic [DI_DATA_W-1:0]               data_q, data_d, rd_data;
    logic                               ready_q, ready_d;
    logic                               bad_q, bad_d;
    logic                               sel, wr_req, rd_req, wr_rw, rd_unmapped, going_done;
    logic                               tmr_load, tmr_en, tmr_done;

    assign sel      = (diEpAddr == EP_ADDR);
    assign wr_req   = sel && diWrite;
    assign rd_req   = sel && diRead;
    assign wr_rw    = wr_req && (diRegAddr < 16'(NUM_REGS));
    assign status_w = status_flat;

    di_rd_timer u_timer (
        .if_clock (if_clock),
        .resetb   (resetb),
        .clr      (diReset),
        .load     (tmr_load),
        .load_val (3'(RD_LATENCY - 1)),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_comb begin
        regs_d     = regs_q;
        trig_d     = '0;
        bad_d      = bad_q;
        state_d    = state_q;
        addr_d     = addr_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        going_done = 1'b0;

        if (wr_req) begin
            if (wr_rw) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (diRegAddr == 16'(i)) begin
                        regs_d[i] = diRegDataIn;
                        trig_d[i] = 1'b1;
                    end
                end
            end else begin
                bad_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: if (rd_req) begin
                addr_d   = diRegAddr;
                tmr_load = 1'b1;
                if (RD_LATENCY == 1) begin
                    going_done = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    going_done = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Data is captured on the edge entering DONE so it is valid alongside the
        // strobe; reading regs_d lets a write on that same edge be seen.
        rd_addr     = (state_q == ST_IDLE) ? diRegAddr : addr_q;
        rd_data     = DI_UNMAPPED_DATA;
        rd_unmapped = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 16'(i)) begin
                rd_data     = regs_d[i];
                rd_unmapped = 1'b0;
            end
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (rd_addr == 16'(NUM_REGS + j)) begin
                rd_data     = status_w[j];
                rd_unmapped = 1'b0;
            end
        end

        ready_d = going_done;
        data_d  = going_done ? rd_data : data_q;
        if (going_done && rd_unmapped)
            bad_d = 1'b1;

        if (diReset) begin
            regs_d  = RESET_VALUES;
            trig_d  = '0;
            bad_d   = 1'b0;
            state_d = ST_IDLE;
            ready_d = 1'b0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge if_clock) begin
        if (!resetb) begin
            regs_q  <= RESET_VALUES;
            trig_q  <= '0;
            bad_q   <= 1'b0;
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            trig_q  <= trig_d;
            bad_q   <= bad_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    assign regs_flat    = regs_q;
    assign trig         = trig_q;
    assign bad_addr     = bad_q;
    assign diRegDataOut = data_q;
    assign rdwr_ready   = ready_q;

endmodule
